// File: rtl/delay_addr_ctrl.sv
// delay_addr_ctrl: write/read address generator for a circular sample delay line.
// It drives a dual-port RAM with synchronous write and registered read (read-before-write).
// Reads are held off until the buffer holds D samples.
module delay_addr_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    din,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     dout_valid,
  output logic                     primed
);

  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] wptr;
  logic [CNT_W-1:0]         fill_cnt;
  logic [CNT_W-1:0]         d_lat;
  logic [ADDRESS_WIDTH-1:0] cur_off;

  logic                     off_chg;
  logic                     fill_done;
  logic [CNT_W-1:0]         d_req;
  logic                     rd_go;
  logic [ADDRESS_WIDTH-1:0] rd_addr_next;
  logic [CNT_W-1:0]         fill_cnt_next;

  // Offset 0 selects the full buffer depth.
  assign d_req     = (offset == '0) ? FULL_DEPTH : {1'b0, offset};
  assign off_chg   = (offset != cur_off);
  assign fill_done = (fill_cnt == d_lat);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next state: an offset change always refills; FILL ends on the strobe that finds D samples.
  always_comb begin
    state_next = state;
    if (en) begin
      if (off_chg) begin
        state_next = FILL;
      end else if ((state == FILL) && fill_done) begin
        state_next = RUN;
      end
    end
  end

  // Per-strobe actions: read decision, read address and fill-count update.
  always_comb begin
    rd_go         = 1'b0;
    rd_addr_next  = wptr - d_lat[ADDRESS_WIDTH-1:0];
    fill_cnt_next = fill_cnt;
    if (en) begin
      if (off_chg) begin
        // The changing strobe is itself written, so it is the first counted sample.
        fill_cnt_next = CNT_W'(1);
      end else if ((state == RUN) || fill_done) begin
        rd_go = 1'b1;
      end else begin
        fill_cnt_next = fill_cnt + CNT_W'(1);
      end
    end
  end

  // Pointer, delay bookkeeping and registered RAM-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      fill_cnt   <= '0;
      cur_off    <= offset;
      d_lat      <= d_req;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      din        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      dout_valid <= 1'b0;
      primed     <= 1'b0;
    end else begin
      wr_en      <= en;
      rd_en      <= rd_go;
      dout_valid <= rd_en;
      primed     <= (state_next == RUN);
      if (en) begin
        wr_addr  <= wptr;
        din      <= sample_in;
        wptr     <= wptr + ADDRESS_WIDTH'(1);
        fill_cnt <= fill_cnt_next;
        if (off_chg) begin
          cur_off <= offset;
          d_lat   <= d_req;
        end
      end
      if (rd_go) begin
        rd_addr <= rd_addr_next;
      end
    end
  end

endmodule

// File: tb/tb_delay_addr_ctrl.sv
// Scoreboard bench for delay_addr_ctrl with a behavioural 512x8 read-before-write RAM.
module tb_delay_addr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [8:0] offset;
  logic [7:0] sample_in;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] din;
  logic       rd_en;
  logic [8:0] rd_addr;
  logic       dout_valid;
  logic       primed;

  delay_addr_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .offset     (offset),
    .sample_in  (sample_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .din        (din),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  // RAM model: registered read returns the old word when addresses collide.
  logic [7:0] mem [512];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (rd_en === 1'b1) ram_q <= mem[rd_addr];
    if (wr_en === 1'b1) mem[wr_addr] <= din;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] wa;
    logic [7:0] d;
    logic       rd;
    logic [8:0] ra;
    int         cyc;
  } wexp_t;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } dexp_t;

  wexp_t wq[$];
  dexp_t dq[$];
  int checks = 0;
  int errors = 0;

  // Issue one strobe and queue its expected write/read and delayed-data responses.
  task automatic strobe(input logic [7:0] s, input logic rd, input logic [8:0] wa,
                        input logic [8:0] ra, input logic [7:0] rdat, input bit nodv);
    wexp_t w;
    dexp_t d;
    int    e;
    e = cyc + 1;
    en = 1'b1;
    sample_in = s;
    w.wa = wa; w.d = s; w.rd = rd; w.ra = ra; w.cyc = e;
    wq.push_back(w);
    if (rd && !nodv) begin
      d.d = rdat; d.cyc = e + 1;
      dq.push_back(d);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [8:0] off);
    offset = off;
    en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({wr_en, rd_en, dout_valid, primed, wr_addr, rd_addr, din} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr_en=%b rd_en=%b dv=%b primed=%b wa=%0d ra=%0d din=%h, need all 0",
               wr_en, rd_en, dout_valid, primed, wr_addr, rd_addr, din);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a write or valid read data.
  wexp_t mw;
  dexp_t md;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wa=%0d din=%h at cycle %0d, need no write", wr_addr, din, cyc);
      end else begin
        mw = wq.pop_front();
        if (wr_addr !== mw.wa || din !== mw.d || rd_en !== mw.rd || primed !== mw.rd ||
            (mw.rd && rd_addr !== mw.ra) || cyc != mw.cyc) begin
          errors++;
          $display("FAIL strobe: got wa=%0d din=%h rd_en=%b ra=%0d primed=%b cyc=%0d, need wa=%0d din=%h rd_en=%b ra=%0d primed=%b cyc=%0d",
                   wr_addr, din, rd_en, rd_addr, primed, cyc, mw.wa, mw.d, mw.rd, mw.ra, mw.rd, mw.cyc);
        end
      end
    end else if (rd_en !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL read_without_write: rd_en=%b at cycle %0d, need 0", rd_en, cyc);
    end
    if (dout_valid === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data=%h at cycle %0d, need no dout_valid", ram_q, cyc);
      end else begin
        md = dq.pop_front();
        if (ram_q !== md.d || cyc != md.cyc) begin
          errors++;
          $display("FAIL delayed_data: got %h at cycle %0d, need %h at cycle %0d", ram_q, cyc, md.d, md.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    en = 1'b0;
    sample_in = 8'h00;
    // Reset then fill, D=4
    do_reset(9'd4);
    for (int i = 0; i < 8; i++)
      strobe(8'(8'h10 + i), i >= 4, 9'(i), 9'(i - 4), 8'(8'h10 + i - 4), 1'b0);
    idle(3);

    // Gapped strobes, D=1
    do_reset(9'd1);
    strobe(8'hA0, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
    idle(2);
    strobe(8'hA1, 1'b1, 9'd1, 9'd0, 8'hA0, 1'b0);
    strobe(8'hA2, 1'b1, 9'd2, 9'd1, 8'hA1, 1'b0);

    // Reset the cycle after a RUN strobe: its read data must never be flagged valid
    strobe(8'hA3, 1'b1, 9'd3, 9'd2, 8'hA2, 1'b1);
    do_reset(9'd1);
    idle(2);
    strobe(8'hB0, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
    idle(3);

    // Wrap-around, D=3
    do_reset(9'd3);
    for (int i = 0; i < 515; i++)
      strobe(8'(i * 5 + 1), i >= 3, 9'(i), 9'(i - 3), 8'((i - 3) * 5 + 1), 1'b0);
    idle(3);

    // Full depth, offset=0: read address equals write address
    do_reset(9'd0);
    for (int i = 0; i < 514; i++)
      strobe(8'(i * 3 + 7), i >= 512, 9'(i), 9'(i), 8'((i - 512) * 3 + 7), 1'b0);
    idle(3);

    // Offset change from 4 to 2 at wptr=20
    do_reset(9'd4);
    for (int i = 0; i < 26; i++) begin
      logic       r;
      logic [8:0] ra;
      if (i == 20) offset = 9'd2;
      r  = (i < 20) ? (i >= 4) : (i >= 22);
      ra = (i < 20) ? 9'(i - 4) : 9'(i - 2);
      strobe(8'(8'h40 + i), r, 9'(i), ra, 8'(8'h40 + ra), 1'b0);
    end
    idle(4);

    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes and %0d reads still pending, need 0 and 0", wq.size(), dq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
